seq_divider: RTL and testbench
==============================

# seq_divider

Iterative unsigned restoring divider that computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the inverse-operation companion to the combinational add/subtract unit: each iteration is a trial subtraction of the divisor from the partial remainder. It sits beside the adder/subtractor in the lab datapath, with a start/busy/done handshake toward the controlling FSM.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on a rising edge of clk.
- A  in  WIDTH  dividend; captured when start is accepted.
- B  in  WIDTH  divisor; captured when start is accepted.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when Q/R become valid.
- Q  out  WIDTH  quotient.
- R  out  WIDTH  remainder.
- err  out  1  divide-by-zero flag; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, busy=0, done=0, Q=0, R=0, err=0, iteration counter=0.
- In IDLE or DONE, start=1 is accepted:
  - A goes to the quotient/shift register.
  - B goes to the divisor register.
  - Partial remainder P (WIDTH+1 bits) is cleared.
  - Counter is loaded with WIDTH.
  - State goes to RUN.
- In RUN, start is ignored. Results are not disturbed.
- RUN step, one per cycle:
  - Shift {P, Qreg} left by one.
  - Compute trial T = P_shifted − {1'b0, B} in WIDTH+1 bits.
  - If T's MSB is 0 (no borrow): P=T and the new Qreg LSB is 1.
  - Otherwise P is kept and the new LSB is 0.
  - Decrement the counter.
- When the counter reaches 0 after the last step:
  - Q ← Qreg and R ← P[WIDTH-1:0].
  - State goes to DONE.
- DONE lasts one cycle with done=1. It then returns to IDLE unless start is accepted in that cycle.
- Q, R and err hold their values until the next completion or a reset.
- All arithmetic is unsigned. R < B is always true for B ≠ 0.
- Divisor 0 with the algorithm running naturally yields Q = all-ones and R = A.

## Timing
- Call the edge that accepts start edge 0.
- busy=1 from edge 0 through edge WIDTH.
- State is DONE after edge WIDTH; done=1 and valid Q/R are visible in the cycle after edge WIDTH.
- Back-to-back: start held high during the DONE cycle starts a new division with no idle cycle. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- rst asserted at any time, including mid-RUN, forces all reset values immediately (asynchronous). The in-flight division is discarded and no done pulse is produced.

## Configuration
- DIVIDER_ZERO_CHECK_EN defined:
  - If the accepted B is 0, the block goes directly to DONE after edge 0. Latency is 1 cycle.
  - Results: Q=all-ones, R=A, err=1.
  - err clears to 0 on the next accepted start with B ≠ 0.
- DIVIDER_ZERO_CHECK_EN undefined:
  - err is tied to 0.
  - B=0 runs the full WIDTH iterations and produces the natural Q=all-ones, R=A.

## Structure
- Shared package div_pkg holds:
  - enum div_state_t {IDLE, RUN, DONE}.
  - Helper function for counter width: $clog2(WIDTH+1).
- One sub-module, div_step: combinational shift plus trial-subtract of a single iteration.
  - Inputs: P, Qreg, B.
  - Outputs: next P, next Qreg.
  - Instantiated once inside seq_divider.

## Test plan
All scenarios use WIDTH=8.
- A=100, B=7, start one cycle → busy for 8 cycles; done in the 9th cycle after edge 0; Q=14, R=2, err=0.
- A=255, B=1 → Q=255, R=0; then A=5, B=9 issued back-to-back during DONE → Q=0, R=5, with no idle cycle between runs.
- A=200, B=0:
  - With DIVIDER_ZERO_CHECK_EN: done one cycle after edge 0, Q=255, R=200, err=1.
  - Without it: done after 9 cycles, Q=255, R=200, err=0.
- A=100, B=7 started, then start with A=9, B=3 pulsed at RUN cycle 3 → second start ignored; result Q=14, R=2.
- A=100, B=7 started, then rst pulsed in RUN cycle 4 → busy=0, done=0, Q=0, R=0 immediately; no done pulse follows.
- Random sweep of 1000 operand pairs with B ≠ 0 → Q*B+R == A and R < B for every pair.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P, Qreg} left, trial-subtract B, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [2*WIDTH:0] cat_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;

  assign cat_s     = {p_i, q_i} << 1;
  assign shifted_s = cat_s[2*WIDTH:WIDTH];
  assign trial_s   = shifted_s - {1'b0, b_i};

  // Keep the trial difference only when it did not borrow.
  always_comb begin
    p_o = shifted_s;
    q_o = cat_s[WIDTH-1:0];
    if (trial_s[WIDTH] == 1'b0) begin
      p_o = trial_s;
      q_o = cat_s[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      p_o = shifted_s;
      q_o = cat_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIVIDER_ZERO_CHECK_EN: divide-by-zero short-circuits to DONE in one cycle and raises err.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] qr_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] qr_d;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic             err_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .q_i (qr_q),
    .b_i (b_q),
    .p_o (p_d),
    .q_o (qr_d)
  );

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      p_q     <= {(WIDTH+1){1'b0}};
      qr_q    <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
`ifdef DIVIDER_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            qr_q  <= A;
            b_q   <= B;
            p_q   <= {(WIDTH+1){1'b0}};
            cnt_q <= CNT_LOAD;
`ifdef DIVIDER_ZERO_CHECK_EN
            if (B == {WIDTH{1'b0}}) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              q_q     <= {WIDTH{1'b1}};
              r_q     <= A;
              err_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // start is deliberately ignored here; results stay untouched until completion.
          p_q   <= p_d;
          qr_q  <= qr_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= qr_d;
            r_q     <= p_d[WIDTH-1:0];
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
`ifdef DIVIDER_ZERO_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): vector table, corner sequences, random sweep.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[8];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned division, with the all-ones/dividend convention for B=0.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r);
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
    end
  endfunction

  function automatic int exp_lat(input logic [7:0] b);
`ifdef DIVIDER_ZERO_CHECK_EN
    return (b == 8'd0) ? 0 : WIDTH;
`else
    return WIDTH;
`endif
  endfunction

  function automatic int exp_err(input logic [7:0] b);
`ifdef DIVIDER_ZERO_CHECK_EN
    return (b == 8'd0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      chk("busy_while_running", int'(busy), 1);
      tick();
      lat++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("busy_done_exclusive", int'(busy & done), 0);
  end

  initial begin
    int lat;
    int extra;
    bit seen_done;
    logic [7:0] ra, rb, mq, mr;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
    vecs[3] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0};
    vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    vecs[6] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254};
    vecs[7] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0};

    rst   = 1'b1;
    start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b);
      if (exp_lat(vecs[i].b) != 0) chk("busy_after_accept", int'(busy), 1);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b));
      chk($sformatf("vec%0d_Q", i), int'(Q), int'(vecs[i].q));
      chk($sformatf("vec%0d_R", i), int'(R), int'(vecs[i].r));
      chk($sformatf("vec%0d_err", i), int'(err), exp_err(vecs[i].b));
      tick();
      chk($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
      chk($sformatf("vec%0d_Q_hold", i), int'(Q), int'(vecs[i].q));
    end

    // Back-to-back: new start held during the DONE cycle.
    launch(8'd255, 8'd1);
    wait_done(lat);
    chk("b2b_first_Q", int'(Q), 255);
    chk("b2b_first_R", int'(R), 0);
    launch(8'd5, 8'd9);
    chk("b2b_no_idle_busy", int'(busy), 1);
    chk("b2b_no_idle_done", int'(done), 0);
    chk("b2b_Q_held_during_run", int'(Q), 255);
    wait_done(lat);
    chk("b2b_second_latency", lat, WIDTH);
    chk("b2b_second_Q", int'(Q), 0);
    chk("b2b_second_R", int'(R), 5);
    tick();

    // start pulsed in RUN cycle 3 must be ignored.
    launch(8'd100, 8'd7);
    tick();
    tick();
    start = 1'b1;
    A     = 8'd9;
    B     = 8'd3;
    tick();
    start = 1'b0;
    wait_done(extra);
    chk("ignore_start_latency", 3 + extra, WIDTH);
    chk("ignore_start_Q", int'(Q), 14);
    chk("ignore_start_R", int'(R), 2);
    tick();

    // Asynchronous reset mid-RUN discards the division.
    launch(8'd100, 8'd7);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_done", int'(done), 0);
    chk("midrun_rst_Q", int'(Q), 0);
    chk("midrun_rst_R", int'(R), 0);
    chk("midrun_rst_err", int'(err), 0);
    #3;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("midrun_rst_no_done", int'(seen_done), 0);

    // Random sweep with nonzero divisors against the arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      ref_div(ra, rb, mq, mr);
      launch(ra, rb);
      wait_done(lat);
      chk("rand_latency", lat, WIDTH);
      chk("rand_identity", int'(Q) * int'(rb) + int'(R), int'(ra));
      chk("rand_R_lt_B", int'(R < rb), 1);
      chk("rand_Q_model", int'(Q), int'(mq));
      chk("rand_R_model", int'(R), int'(mr));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
